imm_extend_pipe: RTL and testbench

//  Registered, parametrised immediate-extension stage for the decode->execute path.

---
 rtl/imm_extend_pipe.sv | 119 +++++++++++
 tb/tb_imm_extend_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : imm_extend_pipe
//  Brief    : Registered immediate-extension stage (sign/zero/upper/branch)
//             with a valid/ready handshake and a 2-entry skid buffer.
//  Revision : 1.0  initial release
// ============================================================================
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int         EXT_W       = OUT_W - IN_W;
    localparam logic [1:0] MODE_SIGN   = 2'd0;
    localparam logic [1:0] MODE_ZERO   = 2'd1;
    localparam logic [1:0] MODE_UPPER  = 2'd2;

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] main_data_q,  main_data_d;
    logic [TAG_W-1:0] main_tag_q,   main_tag_d;
    logic [OUT_W-1:0] skid_data_q,  skid_data_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

    logic [IN_W-1:0]  w_imm;
    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_ext;
    logic             w_in_fire;
    logic             w_out_fire;

    // Gate the raw field so an undriven immediate on idle cycles cannot leak.
    assign w_imm  = in_valid ? in_imm : '0;
    assign w_sext = {{EXT_W{w_imm[IN_W-1]}}, w_imm};

    // Branch form is the sign extension shifted by two; the dropped top bits are
    // copies of the sign, so this also holds when EXT_W is exactly 2.
    always_comb begin
        w_ext = w_sext;
        case (in_mode)
            MODE_SIGN:  w_ext = w_sext;
            MODE_ZERO:  w_ext = {{EXT_W{1'b0}}, w_imm};
            MODE_UPPER: w_ext = {w_imm, {EXT_W{1'b0}}};
            default:    w_ext = w_sext << 2;
        endcase
    end

    assign w_in_fire  = in_valid & ~skid_valid_q;
    assign w_out_fire = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        main_tag_d   = main_tag_q;
        skid_data_d  = skid_data_q;
        skid_tag_d   = skid_tag_q;

        if (!main_valid_q) begin
            if (w_in_fire) begin
                main_valid_d = 1'b1;
                main_data_d  = w_ext;
                main_tag_d   = in_tag;
            end
        end else if (!skid_valid_q) begin
            if (w_in_fire && w_out_fire) begin
                main_data_d  = w_ext;
                main_tag_d   = in_tag;
            end else if (w_in_fire) begin
                skid_valid_d = 1'b1;
                skid_data_d  = w_ext;
                skid_tag_d   = in_tag;
            end else if (w_out_fire) begin
                main_valid_d = 1'b0;
            end
        end else if (w_out_fire) begin
            main_data_d  = skid_data_q;
            main_tag_d   = skid_tag_q;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_tag_q   <= '0;
            skid_data_q  <= '0;
            skid_tag_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            main_tag_q   <= main_tag_d;
            skid_data_q  <= skid_data_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_tag   = main_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_imm_extend_pipe
//  Brief    : Self-checking bench for imm_extend_pipe against a queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imm_extend_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int TAG_W = 5;
    localparam int EXT_W = OUT_W - IN_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm = '0;
    logic [1:0]       in_mode = 2'd0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic [TAG_W-1:0] t;
    } item_t;

    item_t q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Extension by plain integer arithmetic on the immediate's numeric value.
    function automatic logic [OUT_W-1:0] model_ext(input logic [IN_W-1:0] imm, input logic [1:0] mode);
        longint      u, s, r;
        logic [63:0] rb;
        u = longint'(imm);
        s = (u >= (longint'(1) << (IN_W-1))) ? u - (longint'(1) << IN_W) : u;
        case (mode)
            2'd0:    r = s;
            2'd1:    r = u;
            2'd2:    r = u * (longint'(1) << EXT_W);
            default: r = s * 4;
        endcase
        rb = r;
        return rb[OUT_W-1:0];
    endfunction

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic cyc(output bit acc);
        bit    fi, fo;
        item_t it;
        @(negedge clk);
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("in_ready",  64'(in_ready),  64'(q.size() < 2));
        if (q.size() > 0) begin
            check("out_data", 64'(out_data), 64'(q[0].d));
            check("out_tag",  64'(out_tag),  64'(q[0].t));
        end
        fi   = in_valid && in_ready;
        fo   = out_valid && out_ready;
        it.d = model_ext(in_imm, in_mode);
        it.t = in_tag;
        @(posedge clk);
        if (fo && q.size() > 0) void'(q.pop_front());
        if (fi) q.push_back(it);
        acc = fi;
        #1;
    endtask

    task automatic send1(input string name, input logic [IN_W-1:0] imm, input logic [1:0] mode,
                         input logic [TAG_W-1:0] tag, input logic [OUT_W-1:0] exp);
        bit acc;
        in_valid  = 1'b1;
        in_imm    = imm;
        in_mode   = mode;
        in_tag    = tag;
        out_ready = 1'b1;
        cyc(acc);
        in_valid  = 1'b0;
        check({name, "_valid"}, 64'(out_valid), 64'(1));
        check({name, "_data"},  64'(out_data),  64'(exp));
        check({name, "_tag"},   64'(out_tag),   64'(tag));
        cyc(acc);
    endtask

    initial begin
        bit acc;
        int cnt;
        int cycles;

        // Reset held with a valid item pending upstream
        in_valid = 1'b1;
        in_imm   = 16'hABCD;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_out_data",  64'(out_data),  64'(0));
        check("rst_out_tag",   64'(out_tag),   64'(0));
        rst_n = 1'b1;
        #1;
        check("post_rst_out_valid", 64'(out_valid), 64'(0));
        check("post_rst_in_ready",  64'(in_ready),  64'(1));
        check("post_rst_out_data",  64'(out_data),  64'(0));
        in_valid = 1'b0;
        cyc(acc);

        send1("sign",   16'h8001, 2'd0, 5'd1, 32'hFFFF8001);
        send1("zero",   16'h8001, 2'd1, 5'd2, 32'h00008001);
        send1("upper",  16'h1234, 2'd2, 5'd3, 32'h12340000);
        send1("branch", 16'hFFFF, 2'd3, 5'd4, 32'hFFFFFFFC);
        send1("branch_pos", 16'h0005, 2'd3, 5'd5, 32'h00000014);

        // Back-to-back stream with the sink always ready
        cnt = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_imm   = IN_W'($urandom);
            in_mode  = 2'($urandom);
            in_tag   = TAG_W'(i);
            cyc(acc);
            if (acc) cnt++;
        end
        in_valid = 1'b0;
        check("stream_accepted", 64'(cnt), 64'(100));
        repeat (3) cyc(acc);

        // Sink stalled while three items are offered
        cnt = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_imm   = IN_W'($urandom);
            in_mode  = 2'($urandom);
            in_tag   = TAG_W'(20 + i);
            cyc(acc);
            if (acc) cnt++;
        end
        check("stall_accepted", 64'(cnt), 64'(2));
        check("stall_in_ready", 64'(in_ready), 64'(0));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc(acc);
        check("stall_drained", 64'(q.size()), 64'(0));

        // Random valid/ready traffic
        cnt    = 0;
        cycles = 0;
        while (cnt < 10000 && cycles < 60000) begin
            in_valid  = 1'($urandom);
            in_imm    = IN_W'($urandom);
            in_mode   = 2'($urandom);
            in_tag    = TAG_W'(cnt);
            out_ready = 1'($urandom);
            cyc(acc);
            if (acc) cnt++;
            cycles++;
        end
        check("rand_accepted", 64'(cnt), 64'(10000));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc(acc);
        check("rand_drained", 64'(q.size()), 64'(0));

        // Reset asserted while both registers hold items
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_imm   = IN_W'($urandom);
            in_mode  = 2'($urandom);
            in_tag   = TAG_W'(i);
            cyc(acc);
        end
        in_valid = 1'b0;
        check("full_in_ready", 64'(in_ready), 64'(0));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready",  64'(in_ready),  64'(1));
        check("midrst_out_data",  64'(out_data),  64'(0));
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send1("after_rst", 16'h8001, 2'd3, 5'h15, 32'hFFFE0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
